// File: rtl/serializer_if.sv
// Bundle of the serializer's control, sample and serial-output signals.
// The producer of samples uses master; the serializer itself uses slave.
interface serializer_if;
  logic        enable;
  logic [15:0] data_in;
  logic        done;
  logic [15:0] tempdata;
  logic        audio_data;
  logic        audio_enable;
  logic [3:0]  counter;

  modport master (
    output enable, data_in,
    input  done, tempdata, audio_data, audio_enable, counter
  );

  modport slave (
    input  enable, data_in,
    output done, tempdata, audio_data, audio_enable, counter
  );
endinterface

// File: rtl/serializer.sv
// 16-bit parallel-to-serial converter, MSB first, one bit per clock.
// Words stream back-to-back while enable is high at each word boundary.
module serializer (
  input  logic        clock,
  input  logic        reset,
  serializer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [15:0] tempdata_reg, tempdata_next;
  logic [3:0]  counter_reg, counter_next;
  logic        done_reg, done_next;
  logic        audio_enable_reg, audio_enable_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      tempdata_reg     <= 16'd0;
      counter_reg      <= 4'd0;
      done_reg         <= 1'b0;
      audio_enable_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tempdata_reg     <= tempdata_next;
      counter_reg      <= counter_next;
      done_reg         <= done_next;
      audio_enable_reg <= audio_enable_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    tempdata_next     = tempdata_reg;
    counter_next      = counter_reg;
    done_next         = 1'b0;
    audio_enable_next = audio_enable_reg;
    unique case (state_reg)
      IDLE: begin
        counter_next      = 4'd0;
        audio_enable_next = 1'b0;
        if (bus.enable) begin
          tempdata_next     = bus.data_in;
          audio_enable_next = 1'b1;
          state_next        = SHIFT;
        end
      end
      SHIFT: begin
        if (counter_reg != 4'd15) begin
          tempdata_next = {tempdata_reg[14:0], 1'b0};
          counter_next  = counter_reg + 4'd1;
        end else begin
          // Last bit on the line: enable decides between reload and stop.
          done_next    = 1'b1;
          counter_next = 4'd0;
          if (bus.enable) begin
            tempdata_next = bus.data_in;
          end else begin
            tempdata_next     = {tempdata_reg[14:0], 1'b0};
            audio_enable_next = 1'b0;
            state_next        = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.done         = done_reg;
  assign bus.tempdata     = tempdata_reg;
  assign bus.counter      = counter_reg;
  assign bus.audio_enable = audio_enable_reg;
  assign bus.audio_data   = audio_enable_reg & tempdata_reg[15];

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a negedge monitor pops expected bits
// from a scoreboard queue filled by the stimulus tasks.
module tb_serializer;

  logic clock = 1'b0;
  logic reset;

  serializer_if bus ();

  serializer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        bit_val;
    logic [3:0]  idx;
    logic [15:0] td;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    int          nwords;
    int          exp_ones;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   checking = 1'b0;
  bit   exp_done = 1'b0;
  int   done_count = 0;
  int   ones_acc = 0;
  int   last_word_ones = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one comparison set per clock, sampled on the falling edge.
  always @(negedge clock) begin
    if (checking) begin
      chk("done", {15'd0, bus.done}, {15'd0, exp_done});
      exp_done = 1'b0;
      if (bus.done) done_count++;
      if (bus.audio_enable) begin
        if (sb.size() == 0) begin
          chk("unexpected_bit", 16'd1, 16'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("audio_data", {15'd0, bus.audio_data}, {15'd0, e.bit_val});
          chk("counter", {12'd0, bus.counter}, {12'd0, e.idx});
          chk("tempdata", bus.tempdata, e.td);
          if (e.idx == 4'd0) ones_acc = 0;
          ones_acc += int'(bus.audio_data);
          if (e.idx == 4'd15) begin
            last_word_ones = ones_acc;
            exp_done = 1'b1;
          end
        end
      end else begin
        chk("idle_audio_data", {15'd0, bus.audio_data}, 16'd0);
        chk("idle_counter", {12'd0, bus.counter}, 16'd0);
      end
    end
  end

  task automatic push_word(input logic [15:0] d);
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      e.bit_val = d[15-k];
      e.idx     = 4'(k);
      e.td      = d << k;
      sb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Called just after a falling edge; holds enable for n words.
  task automatic send_words(input logic [15:0] d, input int n, input int exp_ones);
    int dc0;
    dc0 = done_count;
    bus.enable  = 1'b1;
    bus.data_in = d;
    for (int w = 0; w < n; w++) begin
      push_word(d);
      step(16);
      chk("word_ones", 16'(last_word_ones), 16'(exp_ones));
      if (w == n - 1) bus.enable = 1'b0;
    end
    step(1);
    chk("done_pulses", 16'(done_count - dc0), 16'(n));
    chk("queue_drained", 16'(sb.size()), 16'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int dc0;
    vecs[0] = '{data: 16'h8001, nwords: 1, exp_ones: 2};
    vecs[1] = '{data: 16'hA5C3, nwords: 3, exp_ones: 8};
    vecs[2] = '{data: 16'h0000, nwords: 1, exp_ones: 0};
    vecs[3] = '{data: 16'hFFFF, nwords: 2, exp_ones: 16};
    vecs[4] = '{data: 16'h1234, nwords: 1, exp_ones: 5};
    vecs[5] = '{data: 16'h7FFE, nwords: 1, exp_ones: 14};

    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.data_in = 16'h0000;
    step(3);
    chk("rst_done", {15'd0, bus.done}, 16'd0);
    chk("rst_tempdata", bus.tempdata, 16'd0);
    chk("rst_counter", {12'd0, bus.counter}, 16'd0);
    chk("rst_audio_enable", {15'd0, bus.audio_enable}, 16'd0);
    chk("rst_audio_data", {15'd0, bus.audio_data}, 16'd0);
    reset    = 1'b0;
    checking = 1'b1;

    // Idle quiescence: the monitor checks every cycle.
    step(100);
    chk("idle_done_count", 16'(done_count), 16'd0);

    for (int i = 0; i < 6; i++) begin
      send_words(vecs[i].data, vecs[i].nwords, vecs[i].exp_ones);
      $display("vector %0d data=%h words=%0d ones=%0d", i, vecs[i].data, vecs[i].nwords, last_word_ones);
      step(3);
    end

    // Mid-word enable toggling and data_in change; drop enable at boundary.
    bus.enable  = 1'b1;
    bus.data_in = 16'h8001;
    push_word(16'h8001);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (k == 1) bus.enable = 1'b0;
      if (k == 5) begin bus.enable = 1'b1; bus.data_in = 16'hFFFF; end
      if (k == 9) bus.enable = 1'b0;
    end
    step(3);
    chk("midword_ones", 16'(last_word_ones), 16'd2);
    chk("midword_idle", {15'd0, bus.audio_enable}, 16'd0);
    chk("midword_queue", 16'(sb.size()), 16'd0);
    $display("midword no-reload done");

    // Same toggling, but enable high at the boundary reloads the new data.
    bus.enable  = 1'b1;
    bus.data_in = 16'h8001;
    push_word(16'h8001);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (k == 2) bus.enable = 1'b0;
      if (k == 6) bus.data_in = 16'hFFFF;
      if (k == 16) begin bus.enable = 1'b1; bus.data_in = 16'h0F0F; end
    end
    push_word(16'h0F0F);
    step(16);
    bus.enable = 1'b0;
    chk("reload_ones", 16'(last_word_ones), 16'd8);
    step(3);
    chk("reload_queue", 16'(sb.size()), 16'd0);
    $display("midword reload done");

    // Reset while counter = 7: word discarded, no done pulse.
    dc0 = done_count;
    bus.enable  = 1'b1;
    bus.data_in = 16'h8001;
    push_word(16'h8001);
    step(1);
    bus.enable = 1'b0;
    step(7);
    chk("pre_reset_counter", {12'd0, bus.counter}, 16'd7);
    reset = 1'b1;
    sb.delete();
    step(1);
    chk("mid_rst_counter", {12'd0, bus.counter}, 16'd0);
    chk("mid_rst_tempdata", bus.tempdata, 16'd0);
    chk("mid_rst_audio_enable", {15'd0, bus.audio_enable}, 16'd0);
    chk("mid_rst_audio_data", {15'd0, bus.audio_data}, 16'd0);
    reset = 1'b0;
    step(20);
    chk("mid_rst_no_done", 16'(done_count - dc0), 16'd0);
    send_words(16'hC001, 1, 3);
    $display("reset mid-word done");

    // Reset and enable together: reset wins, load on first edge after release.
    reset       = 1'b1;
    bus.enable  = 1'b1;
    bus.data_in = 16'h8001;
    step(2);
    chk("rst_en_audio_enable", {15'd0, bus.audio_enable}, 16'd0);
    reset = 1'b0;
    send_words(16'h8001, 1, 2);
    step(5);
    $display("reset with enable done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
